// File: rtl/issue_scoreboard.sv
// Issue stage: holds one decoded op, tracks pending register writes, and stalls on RAW/WAW hazards, full or unresolved control flow.
// Latency: an accepted op appears on iss_* the next cycle; scoreboard and count update on the same edge.
// Backpressure: dec_ready_o drops on hazard, full, WAIT_CF, flush or a held issue register; iss_* hold until execute takes them.
module issue_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic [ADDR_W-1:0]   dec_rs1_i,
  input  logic [ADDR_W-1:0]   dec_rs2_i,
  input  logic [ADDR_W-1:0]   dec_rd_i,
  input  logic                dec_uses_rs1_i,
  input  logic                dec_uses_rs2_i,
  input  logic                dec_reg_write_i,
  input  logic                dec_cf_i,
  output logic                iss_valid_o,
  input  logic                iss_ready_i,
  output logic [ADDR_W-1:0]   iss_rs1_o,
  output logic [ADDR_W-1:0]   iss_rs2_o,
  output logic [ADDR_W-1:0]   iss_rd_o,
  output logic                iss_reg_write_o,
  output logic                iss_cf_o,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wb_rd_i,
  input  logic                cf_resolve_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [CNT_W-1:0]    inflight_cnt_o,
  output logic                stall_o
);

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_CF = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                in_run;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [1:0]          dec_amt;

  logic                rs1_hit;
  logic                rs2_hit;
  logic                rd_hit;
  logic                hazard;
  logic                full;
  logic                slot_free;
  logic                accept;
  logic                set_en;
  logic                wb_hit;
  logic                kill_hit;
  logic                kill_dup;

  // Hazard detection against the registered scoreboard only (no writeback bypass)
  always_comb begin
    rs1_hit = dec_uses_rs1_i && pending[dec_rs1_i];
    rs2_hit = dec_uses_rs2_i && pending[dec_rs2_i];
    rd_hit  = dec_reg_write_i && (dec_rd_i != '0) && pending[dec_rd_i];
    hazard  = rs1_hit || rs2_hit || rd_hit;
    // x0 writes and non-writing ops do not consume an inflight slot, so they pass when full
    full    = (cnt == CNT_W'(MAX_INFLIGHT)) && dec_reg_write_i && (dec_rd_i != '0);
  end

  // Decoder handshake and the scoreboard set/clear events it drives
  always_comb begin
    slot_free   = !iss_valid_o || iss_ready_i;
    dec_ready_o = in_run && slot_free && !hazard && !full && !flush_i;
    accept      = dec_valid_i && dec_ready_o;
    stall_o     = dec_valid_i && !dec_ready_o;
    set_en      = accept && dec_reg_write_i && (dec_rd_i != '0);
    wb_hit      = wb_valid_i && (wb_rd_i != '0) && pending[wb_rd_i];
    // A flushed op only gives back its slot if its bit is still set; guards against underflow
    kill_hit    = flush_i && iss_valid_o && iss_reg_write_o && (iss_rd_o != '0) && pending[iss_rd_o];
    // Same-register writeback and kill clear one bit, so they only count once
    kill_dup    = kill_hit && wb_hit && (wb_rd_i == iss_rd_o);
  end

  // Next scoreboard contents and outstanding-write count
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)   set_mask = NUM_REGS'(1) << dec_rd_i;
    if (wb_hit)   clr_mask = clr_mask | (NUM_REGS'(1) << wb_rd_i);
    if (kill_hit) clr_mask = clr_mask | (NUM_REGS'(1) << iss_rd_o);
    pending_nxt    = (pending | set_mask) & ~clr_mask;
    pending_nxt[0] = 1'b0;
    dec_amt = {1'b0, wb_hit} + {1'b0, kill_hit && !kill_dup};
    cnt_nxt = cnt + CNT_W'(set_en) - CNT_W'(dec_amt);
  end

  // Scoreboard and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign pending_o      = pending;
  assign inflight_cnt_o = cnt;

  // Control-flow FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Control-flow FSM next state: block issue after a branch/jump until resolve or flush
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && dec_cf_i)          state_nxt = WAIT_CF;
      WAIT_CF: if (cf_resolve_i || flush_i)     state_nxt = RUN;
      default:                                  state_nxt = RUN;
    endcase
  end

  // Control-flow FSM outputs
  always_comb begin
    in_run = (state == RUN);
  end

  // Issue register: flush kills, accept loads (also covers back-to-back), handshake empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_o     <= 1'b0;
      iss_rs1_o       <= '0;
      iss_rs2_o       <= '0;
      iss_rd_o        <= '0;
      iss_reg_write_o <= 1'b0;
      iss_cf_o        <= 1'b0;
    end else if (flush_i) begin
      iss_valid_o     <= 1'b0;
    end else if (accept) begin
      iss_valid_o     <= 1'b1;
      iss_rs1_o       <= dec_rs1_i;
      iss_rs2_o       <= dec_rs2_i;
      iss_rd_o        <= dec_rd_i;
      iss_reg_write_o <= dec_reg_write_i;
      iss_cf_o        <= dec_cf_i;
    end else if (iss_valid_o && iss_ready_i) begin
      iss_valid_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: expected issued ops queued at accept, compared when execute takes them.
// Inputs driven 2ns after the rising edge; combinational outputs sampled on the falling edge.
// Registered outputs are checked at the drive point after the edge that updates them.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid_i, dec_ready_o;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic        dec_uses_rs1_i, dec_uses_rs2_i, dec_reg_write_i, dec_cf_i;
  logic        iss_valid_o, iss_ready_i;
  logic [4:0]  iss_rs1_o, iss_rs2_o, iss_rd_o;
  logic        iss_reg_write_o, iss_cf_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        cf_resolve_i, flush_i;
  logic [31:0] pending_o;
  logic [2:0]  inflight_cnt_o;
  logic        stall_o;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       cf;
  } op_t;

  op_t exp_q[$];
  op_t cur_op;
  op_t mon_op;
  op_t dummy;
  int  n_cmp = 0;
  int  n_bad = 0;

  issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_uses_rs1_i(dec_uses_rs1_i), .dec_uses_rs2_i(dec_uses_rs2_i),
    .dec_reg_write_i(dec_reg_write_i), .dec_cf_i(dec_cf_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rs1_o(iss_rs1_o), .iss_rs2_o(iss_rs2_o), .iss_rd_o(iss_rd_o),
    .iss_reg_write_o(iss_reg_write_o), .iss_cf_o(iss_cf_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .cf_resolve_i(cf_resolve_i), .flush_i(flush_i),
    .pending_o(pending_o), .inflight_cnt_o(inflight_cnt_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Execute-side monitor: every taken op must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && iss_valid_o && iss_ready_i && !flush_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        $display("FAIL issue_unexpected: got rd=%0d, expected no issue", iss_rd_o);
        n_bad++;
      end else begin
        mon_op = exp_q.pop_front();
        if ({iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_cf_o} !==
            {mon_op.rs1, mon_op.rs2, mon_op.rd, mon_op.rw, mon_op.cf}) begin
          $display("FAIL issue_fields: got rs1=%0d rs2=%0d rd=%0d rw=%0b cf=%0b, expected rs1=%0d rs2=%0d rd=%0d rw=%0b cf=%0b",
                   iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_cf_o,
                   mon_op.rs1, mon_op.rs2, mon_op.rd, mon_op.rw, mon_op.cf);
          n_bad++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic rw, input logic cf);
    dec_valid_i = 1'b1;
    dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
    dec_uses_rs1_i = u1; dec_uses_rs2_i = u2;
    dec_reg_write_i = rw; dec_cf_i = cf;
    cur_op.rs1 = rs1; cur_op.rs2 = rs2; cur_op.rd = rd; cur_op.rw = rw; cur_op.cf = cf;
  endtask

  task automatic idle();
    dec_valid_i = 1'b0;
    dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
    dec_uses_rs1_i = 1'b0; dec_uses_rs2_i = 1'b0;
    dec_reg_write_i = 1'b0; dec_cf_i = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid_i = v;
    wb_rd_i    = rd;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (iss_valid_o !== 1'b0) begin $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid_o); n_bad++; end
    n_cmp++; if (pending_o !== 32'h0) begin $display("FAIL reset_pending: got %08h expected 00000000", pending_o); n_bad++; end
    n_cmp++; if (inflight_cnt_o !== 3'd0) begin $display("FAIL reset_cnt: got %0d expected 0", inflight_cnt_o); n_bad++; end
    n_cmp++; if ({iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_cf_o} !== 17'h0) begin
      $display("FAIL reset_iss_fields: got %05h expected 00000", {iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_cf_o}); n_bad++; end
    n_cmp++; if (stall_o !== 1'b0) begin $display("FAIL reset_stall: got %0b expected 0", stall_o); n_bad++; end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_raw();
    step(); set_op(1, 2, 3, 1, 1, 1, 0);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL raw_accept: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); set_op(3, 0, 8, 1, 0, 1, 0);
    n_cmp++; if (iss_valid_o !== 1'b1) begin $display("FAIL raw_iss_valid: got %0b expected 1", iss_valid_o); n_bad++; end
    n_cmp++; if (pending_o !== 32'h8) begin $display("FAIL raw_pending: got %08h expected 00000008", pending_o); n_bad++; end
    n_cmp++; if (inflight_cnt_o !== 3'd1) begin $display("FAIL raw_cnt: got %0d expected 1", inflight_cnt_o); n_bad++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (stall_o !== 1'b1) begin $display("FAIL raw_stall_%0d: got %0b expected 1", i, stall_o); n_bad++; end
      step();
    end
    wb(1'b1, 5'd3);
    @(negedge clk);
    n_cmp++; if (stall_o !== 1'b1) begin $display("FAIL raw_no_bypass: got stall=%0b expected 1", stall_o); n_bad++; end
    step(); wb(1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL raw_after_wb: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); idle(); wb(1'b1, 5'd8);
    n_cmp++; if (pending_o !== 32'h100) begin $display("FAIL raw_pending2: got %08h expected 00000100", pending_o); n_bad++; end
    step(); wb(1'b0, 5'd0);
    n_cmp++; if (pending_o !== 32'h0 || inflight_cnt_o !== 3'd0) begin
      $display("FAIL raw_drain: got pending=%08h cnt=%0d expected 00000000/0", pending_o, inflight_cnt_o); n_bad++; end
  endtask

  task automatic test_cap();
    for (int r = 4; r <= 7; r++) begin
      step(); set_op(1, 2, 5'(r), 1, 1, 1, 0);
      @(negedge clk);
      n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL cap_fill_x%0d: got ready=%0b expected 1", r, dec_ready_o); n_bad++; end
      exp_q.push_back(cur_op);
    end
    step(); set_op(1, 2, 10, 1, 1, 1, 0);
    n_cmp++; if (inflight_cnt_o !== 3'd4 || pending_o !== 32'hF0) begin
      $display("FAIL cap_full_state: got cnt=%0d pending=%08h expected 4/000000f0", inflight_cnt_o, pending_o); n_bad++; end
    @(negedge clk);
    n_cmp++; if (stall_o !== 1'b1) begin $display("FAIL cap_fifth_stall: got %0b expected 1", stall_o); n_bad++; end
    step(); set_op(1, 2, 0, 1, 1, 1, 0);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL cap_x0_write: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); set_op(1, 2, 11, 1, 1, 0, 0);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL cap_no_write: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); idle(); wb(1'b1, 5'd4);
    n_cmp++; if (inflight_cnt_o !== 3'd4 || pending_o !== 32'hF0) begin
      $display("FAIL cap_untracked: got cnt=%0d pending=%08h expected 4/000000f0", inflight_cnt_o, pending_o); n_bad++; end
    step(); wb(1'b1, 5'd9);
    n_cmp++; if (inflight_cnt_o !== 3'd3 || pending_o !== 32'hE0) begin
      $display("FAIL cap_wb_x4: got cnt=%0d pending=%08h expected 3/000000e0", inflight_cnt_o, pending_o); n_bad++; end
    step(); wb(1'b1, 5'd0);
    n_cmp++; if (inflight_cnt_o !== 3'd3 || pending_o !== 32'hE0) begin
      $display("FAIL cap_wb_x9_ignored: got cnt=%0d pending=%08h expected 3/000000e0", inflight_cnt_o, pending_o); n_bad++; end
    step(); wb(1'b1, 5'd5); set_op(1, 2, 12, 1, 1, 1, 0);
    n_cmp++; if (inflight_cnt_o !== 3'd3 || pending_o !== 32'hE0) begin
      $display("FAIL cap_wb_x0_ignored: got cnt=%0d pending=%08h expected 3/000000e0", inflight_cnt_o, pending_o); n_bad++; end
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL cap_inc_dec_accept: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); idle(); wb(1'b1, 5'd6);
    n_cmp++; if (inflight_cnt_o !== 3'd3 || pending_o !== 32'h10C0) begin
      $display("FAIL cap_inc_dec: got cnt=%0d pending=%08h expected 3/000010c0", inflight_cnt_o, pending_o); n_bad++; end
    step(); wb(1'b1, 5'd7);
    step(); wb(1'b1, 5'd12);
    step(); wb(1'b0, 5'd0);
    n_cmp++; if (inflight_cnt_o !== 3'd0 || pending_o !== 32'h0) begin
      $display("FAIL cap_drain: got cnt=%0d pending=%08h expected 0/00000000", inflight_cnt_o, pending_o); n_bad++; end
  endtask

  task automatic test_branch();
    step(); set_op(1, 2, 0, 1, 1, 0, 1);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL br_accept: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); set_op(1, 2, 13, 1, 1, 1, 0);
    n_cmp++; if (iss_cf_o !== 1'b1) begin $display("FAIL br_iss_cf: got %0b expected 1", iss_cf_o); n_bad++; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (dec_ready_o !== 1'b0) begin $display("FAIL br_wait_%0d: got ready=%0b expected 0", i, dec_ready_o); n_bad++; end
      step();
    end
    cf_resolve_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b0) begin $display("FAIL br_resolve_cycle: got ready=%0b expected 0", dec_ready_o); n_bad++; end
    step(); cf_resolve_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL br_after_resolve: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); idle(); wb(1'b1, 5'd13);
    step(); wb(1'b0, 5'd0);
  endtask

  task automatic test_hold_flush();
    step(); set_op(1, 2, 16, 1, 1, 1, 0);
    @(negedge clk);
    exp_q.push_back(cur_op);
    step(); set_op(1, 2, 14, 1, 1, 1, 0);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL hold_load: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); iss_ready_i = 1'b0; set_op(1, 2, 15, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({iss_valid_o, iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_cf_o} !== {1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0}) begin
        $display("FAIL hold_stable_%0d: got v=%0b rd=%0d rs1=%0d rs2=%0d expected v=1 rd=14 rs1=1 rs2=2", i, iss_valid_o, iss_rd_o, iss_rs1_o, iss_rs2_o); n_bad++; end
      @(negedge clk);
      n_cmp++; if (dec_ready_o !== 1'b0) begin $display("FAIL hold_ready_%0d: got %0b expected 0", i, dec_ready_o); n_bad++; end
      step();
    end
    n_cmp++; if (inflight_cnt_o !== 3'd2) begin $display("FAIL hold_cnt: got %0d expected 2", inflight_cnt_o); n_bad++; end
    flush_i = 1'b1; wb(1'b1, 5'd16);
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b0) begin $display("FAIL flush_ready: got %0b expected 0", dec_ready_o); n_bad++; end
    dummy = exp_q.pop_front();
    step(); flush_i = 1'b0; wb(1'b0, 5'd0); idle();
    n_cmp++; if (iss_valid_o !== 1'b0 || pending_o !== 32'h0 || inflight_cnt_o !== 3'd0) begin
      $display("FAIL flush_wb_restore: got v=%0b pending=%08h cnt=%0d expected 0/00000000/0", iss_valid_o, pending_o, inflight_cnt_o); n_bad++; end
    set_op(3, 4, 0, 1, 1, 0, 1);
    @(negedge clk);
    exp_q.push_back(cur_op);
    step(); set_op(1, 2, 15, 1, 1, 1, 0);
    step(); flush_i = 1'b1;
    @(negedge clk);
    dummy = exp_q.pop_front();
    step(); flush_i = 1'b0; iss_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL flush_leaves_wait_cf: got ready=%0b expected 1", dec_ready_o); n_bad++; end
    exp_q.push_back(cur_op);
    step(); idle(); wb(1'b1, 5'd15);
    step(); wb(1'b0, 5'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      step(); set_op(5'(i + 1), 5'(i + 2), 5'(i + 20), 1, 1, 0, 0);
      if (i > 0) begin
        n_cmp++; if (iss_valid_o !== 1'b1 || iss_rd_o !== 5'(i + 19)) begin
          $display("FAIL b2b_iss_%0d: got v=%0b rd=%0d expected v=1 rd=%0d", i, iss_valid_o, iss_rd_o, i + 19); n_bad++; end
      end
      @(negedge clk);
      n_cmp++; if (dec_ready_o !== 1'b1) begin $display("FAIL b2b_ready_%0d: got %0b expected 1", i, dec_ready_o); n_bad++; end
      exp_q.push_back(cur_op);
    end
    step(); idle();
    step();
    n_cmp++; if (iss_valid_o !== 1'b0) begin $display("FAIL b2b_drain: got v=%0b expected 0", iss_valid_o); n_bad++; end
  endtask

  task automatic test_async_reset();
    step(); set_op(1, 2, 20, 1, 1, 1, 0);
    @(negedge clk);
    exp_q.push_back(cur_op);
    step(); set_op(20, 0, 21, 1, 0, 1, 0);
    @(negedge clk);
    n_cmp++; if (stall_o !== 1'b1) begin $display("FAIL arst_pre_stall: got %0b expected 1", stall_o); n_bad++; end
    step(); #1 rst_n = 1'b0; #1;
    n_cmp++; if ({iss_valid_o, pending_o, inflight_cnt_o, iss_rd_o, stall_o} !== 42'h0) begin
      $display("FAIL arst_clear: got v=%0b pending=%08h cnt=%0d rd=%0d stall=%0b expected all 0",
               iss_valid_o, pending_o, inflight_cnt_o, iss_rd_o, stall_o); n_bad++; end
    idle();
    step(); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; iss_ready_i = 1'b1; cf_resolve_i = 1'b0; flush_i = 1'b0;
    idle(); wb(1'b0, 5'd0);
    test_reset();
    test_raw();
    test_cap();
    test_branch();
    test_hold_flush();
    test_back_to_back();
    test_async_reset();
    step();
    n_cmp++; if (exp_q.size() != 0) begin $display("FAIL queue_leftover: got %0d ops expected 0", exp_q.size()); n_bad++; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
